// File: rtl/tage_bank.sv
// TAGE tagged bank: registered tag-compare lookup, train/alloc updates,
// self-clearing after reset and periodic halving of the useful counters.
module tage_bank #(
    parameter int IL         = 10,
    parameter int TAG_LEN    = 8,
    parameter int UL         = 2,
    parameter int CL         = 3,
    parameter int AGE_PERIOD = 256
) (
    input  logic               Clk,
    input  logic               reset,
    output logic               init_done,
    input  logic               lkp_valid,
    output logic               lkp_ready,
    input  logic [IL-1:0]      lkp_index,
    input  logic [TAG_LEN-1:0] lkp_tag,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic               rsp_pred,
    output logic               rsp_weak,
    output logic [UL-1:0]      rsp_u,
    output logic [CL-1:0]      rsp_ctr,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic               upd_op,
    input  logic [IL-1:0]      upd_index,
    input  logic [TAG_LEN-1:0] upd_tag,
    input  logic               upd_taken,
    input  logic               upd_u_inc,
    input  logic               upd_u_dec,
    output logic               upd_alloc_fail
);
    localparam int DEPTH = 1 << IL;
    localparam int AW    = $clog2(AGE_PERIOD + 1);
    localparam logic [CL-1:0] CTR_WT = {1'b1, {(CL-1){1'b0}}};
    localparam logic [CL-1:0] CTR_WN = {1'b0, {(CL-1){1'b1}}};

    typedef enum logic [1:0] {INIT, RUN, AGE} state_e;

    state_e          state_q, state_d;
    logic [IL-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   age_cnt_q, age_cnt_d;

    logic               mem_v_q   [DEPTH];
    logic [TAG_LEN-1:0] mem_tag_q [DEPTH];
    logic [CL-1:0]      mem_ctr_q [DEPTH];
    logic [UL-1:0]      mem_u_q   [DEPTH];

    logic               rsp_valid_q, rsp_hit_q, rsp_pred_q, rsp_weak_q;
    logic [UL-1:0]      rsp_u_q;
    logic [CL-1:0]      rsp_ctr_q;
    logic               fail_q;

    logic               lkp_fire, upd_fire, age_hit;
    logic               l_hit;
    logic [CL-1:0]      l_ctr;
    logic [UL-1:0]      l_u;
    logic               cur_v;
    logic [CL-1:0]      cur_ctr, ctr_inc, ctr_dec, train_ctr;
    logic [UL-1:0]      cur_u, u_inc, u_dec, train_u;
    logic               alloc_ok;

    assign init_done = (state_q != INIT);
    assign lkp_ready = (state_q != INIT);
    assign upd_ready = (state_q == RUN);
    assign lkp_fire  = lkp_valid & lkp_ready;
    assign upd_fire  = upd_valid & upd_ready;
    assign age_hit   = upd_fire && (age_cnt_q == AW'(AGE_PERIOD - 1));

    assign l_hit = mem_v_q[lkp_index] && (mem_tag_q[lkp_index] == lkp_tag);
    assign l_ctr = l_hit ? mem_ctr_q[lkp_index] : '0;
    assign l_u   = l_hit ? mem_u_q[lkp_index] : '0;

    assign cur_v     = mem_v_q[upd_index];
    assign cur_ctr   = mem_ctr_q[upd_index];
    assign cur_u     = mem_u_q[upd_index];
    assign ctr_inc   = (&cur_ctr) ? cur_ctr : cur_ctr + CL'(1);
    assign ctr_dec   = (cur_ctr == '0) ? cur_ctr : cur_ctr - CL'(1);
    assign u_inc     = (&cur_u) ? cur_u : cur_u + UL'(1);
    assign u_dec     = (cur_u == '0) ? cur_u : cur_u - UL'(1);
    assign train_ctr = !cur_v ? cur_ctr : (upd_taken ? ctr_inc : ctr_dec);
    assign train_u   = upd_u_inc ? u_inc : (upd_u_dec ? u_dec : cur_u);
    assign alloc_ok  = (cur_u == '0);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        age_cnt_d = age_cnt_q;
        unique case (state_q)
            INIT: begin
                ptr_d = ptr_q + IL'(1);
                if (&ptr_q) state_d = RUN;
            end
            RUN: begin
                if (upd_fire) age_cnt_d = age_cnt_q + AW'(1);
                if (age_hit) begin
                    state_d = AGE;
                    ptr_d   = '0;
                end
            end
            AGE: begin
                ptr_d = ptr_q + IL'(1);
                if (&ptr_q) begin
                    state_d   = RUN;
                    age_cnt_d = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            age_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_pred_q  <= 1'b0;
            rsp_weak_q  <= 1'b0;
            rsp_u_q     <= '0;
            rsp_ctr_q   <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            age_cnt_q   <= age_cnt_d;
            rsp_valid_q <= lkp_fire;
            fail_q      <= upd_fire & upd_op & !alloc_ok;
            if (lkp_fire) begin
                rsp_hit_q  <= l_hit;
                rsp_pred_q <= l_ctr[CL-1];
                rsp_weak_q <= l_hit && (l_ctr == CTR_WT || l_ctr == CTR_WN);
                rsp_u_q    <= l_u;
                rsp_ctr_q  <= l_ctr;
            end
        end
    end

    // Writes only commit out of reset; lookups see the pre-write contents.
    always_ff @(posedge Clk) begin
        if (reset) begin
            unique case (1'b1)
                state_q == INIT: begin
                    mem_v_q[ptr_q]   <= 1'b0;
                    mem_tag_q[ptr_q] <= '0;
                    mem_ctr_q[ptr_q] <= '0;
                    mem_u_q[ptr_q]   <= '0;
                end
                state_q == AGE: begin
                    mem_u_q[ptr_q] <= mem_u_q[ptr_q] >> 1;
                end
                upd_fire && !upd_op: begin
                    mem_ctr_q[upd_index] <= train_ctr;
                    mem_u_q[upd_index]   <= train_u;
                end
                upd_fire && upd_op && alloc_ok: begin
                    mem_v_q[upd_index]   <= 1'b1;
                    mem_tag_q[upd_index] <= upd_tag;
                    mem_ctr_q[upd_index] <= upd_taken ? CTR_WT : CTR_WN;
                    mem_u_q[upd_index]   <= '0;
                end
                upd_fire && upd_op && !alloc_ok: begin
                    mem_u_q[upd_index] <= u_dec;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_hit        = rsp_hit_q;
    assign rsp_pred       = rsp_pred_q;
    assign rsp_weak       = rsp_weak_q;
    assign rsp_u          = rsp_u_q;
    assign rsp_ctr        = rsp_ctr_q;
    assign upd_alloc_fail = fail_q;
endmodule

// File: tb/tb_tage_bank.sv
// Bench for tage_bank: directed literal checks plus randomized traffic
// compared every cycle against a table-level model of the bank.
module tb_tage_bank;
    localparam int IL   = 10;
    localparam int TL   = 8;
    localparam int UL   = 2;
    localparam int CL   = 3;
    localparam int AP   = 4;
    localparam int D    = 1 << IL;
    localparam int HALF = 1 << (CL - 1);
    localparam int CMAX = (1 << CL) - 1;
    localparam int UMAX = (1 << UL) - 1;

    logic          Clk = 1'b0;
    logic          reset;
    logic          init_done;
    logic          lkp_valid, lkp_ready;
    logic [IL-1:0] lkp_index;
    logic [TL-1:0] lkp_tag;
    logic          rsp_valid, rsp_hit, rsp_pred, rsp_weak;
    logic [UL-1:0] rsp_u;
    logic [CL-1:0] rsp_ctr;
    logic          upd_valid, upd_ready, upd_op;
    logic [IL-1:0] upd_index;
    logic [TL-1:0] upd_tag;
    logic          upd_taken, upd_u_inc, upd_u_dec;
    logic          upd_alloc_fail;

    tage_bank #(
        .IL(IL), .TAG_LEN(TL), .UL(UL), .CL(CL), .AGE_PERIOD(AP)
    ) dut (
        .Clk(Clk), .reset(reset), .init_done(init_done),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready),
        .lkp_index(lkp_index), .lkp_tag(lkp_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_pred(rsp_pred),
        .rsp_weak(rsp_weak), .rsp_u(rsp_u), .rsp_ctr(rsp_ctr),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
        .upd_index(upd_index), .upd_tag(upd_tag), .upd_taken(upd_taken),
        .upd_u_inc(upd_u_inc), .upd_u_dec(upd_u_dec),
        .upd_alloc_fail(upd_alloc_fail)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: phase 0 = clearing, 1 = serving, 2 = aging sweep.
    bit m_v   [D];
    int m_tag [D];
    int m_ctr [D];
    int m_u   [D];
    int m_phase = 0;
    int m_cnt   = 0;
    int m_ucnt  = 0;
    int e_rv = 0, e_hit = 0, e_pred = 0, e_weak = 0, e_u = 0, e_ctr = 0, e_fail = 0;
    int mi;
    bit mh;

    always @(posedge Clk) begin
        if (!reset) begin
            m_phase = 0; m_cnt = 0; m_ucnt = 0;
            e_rv = 0; e_hit = 0; e_pred = 0; e_weak = 0;
            e_u = 0; e_ctr = 0; e_fail = 0;
        end else begin
            e_rv = (lkp_valid && m_phase != 0) ? 1 : 0;
            if (e_rv == 1) begin
                mi     = int'(lkp_index);
                mh     = m_v[mi] && (m_tag[mi] == int'(lkp_tag));
                e_hit  = mh ? 1 : 0;
                e_ctr  = mh ? m_ctr[mi] : 0;
                e_u    = mh ? m_u[mi] : 0;
                e_pred = (e_ctr >= HALF) ? 1 : 0;
                e_weak = (mh && (e_ctr == HALF || e_ctr == HALF - 1)) ? 1 : 0;
            end
            e_fail = 0;
            if (m_phase == 0) begin
                m_cnt++;
                if (m_cnt == D) begin
                    for (int k = 0; k < D; k++) begin
                        m_v[k] = 0; m_tag[k] = 0; m_ctr[k] = 0; m_u[k] = 0;
                    end
                    m_phase = 1; m_cnt = 0;
                end
            end else if (m_phase == 2) begin
                m_u[m_cnt] = m_u[m_cnt] / 2;
                m_cnt++;
                if (m_cnt == D) begin
                    m_phase = 1; m_cnt = 0; m_ucnt = 0;
                end
            end else if (upd_valid) begin
                mi = int'(upd_index);
                if (!upd_op) begin
                    if (m_v[mi]) begin
                        if (upd_taken) m_ctr[mi] = (m_ctr[mi] < CMAX) ? m_ctr[mi] + 1 : CMAX;
                        else           m_ctr[mi] = (m_ctr[mi] > 0) ? m_ctr[mi] - 1 : 0;
                    end
                    if (upd_u_inc)      m_u[mi] = (m_u[mi] < UMAX) ? m_u[mi] + 1 : UMAX;
                    else if (upd_u_dec) m_u[mi] = (m_u[mi] > 0) ? m_u[mi] - 1 : 0;
                end else if (m_u[mi] == 0) begin
                    m_v[mi]   = 1;
                    m_tag[mi] = int'(upd_tag);
                    m_ctr[mi] = upd_taken ? HALF : HALF - 1;
                end else begin
                    m_u[mi] = m_u[mi] - 1;
                    e_fail  = 1;
                end
                m_ucnt++;
                if (m_ucnt == AP) begin
                    m_phase = 2; m_cnt = 0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("init_done", int'(init_done), (m_phase != 0) ? 1 : 0);
            chk("lkp_ready", int'(lkp_ready), (m_phase != 0) ? 1 : 0);
            chk("upd_ready", int'(upd_ready), (m_phase == 1) ? 1 : 0);
            chk("rsp_valid", int'(rsp_valid), e_rv);
            chk("rsp_hit",   int'(rsp_hit),   e_hit);
            chk("rsp_pred",  int'(rsp_pred),  e_pred);
            chk("rsp_weak",  int'(rsp_weak),  e_weak);
            chk("rsp_u",     int'(rsp_u),     e_u);
            chk("rsp_ctr",   int'(rsp_ctr),   e_ctr);
            chk("alloc_fail", int'(upd_alloc_fail), e_fail);
        end
    end

    task automatic do_lkp(input int idx, input int tag);
        lkp_valid = 1'b1;
        lkp_index = IL'(idx);
        lkp_tag   = TL'(tag);
        @(negedge Clk);
        lkp_valid = 1'b0;
    endtask

    task automatic do_upd(input int op, input int idx, input int tag,
                          input int tk, input int inc, input int dec,
                          output int f);
        int w = 0;
        while (!upd_ready && w < 3000) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 3000) chk("upd_ready_timeout", 0, 1);
        upd_valid = 1'b1;
        upd_op    = op[0];
        upd_index = IL'(idx);
        upd_tag   = TL'(tag);
        upd_taken = tk[0];
        upd_u_inc = inc[0];
        upd_u_dec = dec[0];
        @(negedge Clk);
        upd_valid = 1'b0;
        f = int'(upd_alloc_fail);
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        do begin
            @(posedge Clk);
            n++;
            #1;
        end while (!init_done && n < 2000);
        chk(nm, n, D);
        @(negedge Clk);
    endtask

    int f;
    int acc;
    int cyc;
    int n;

    initial begin
        reset = 1'b0;
        lkp_valid = 1'b0; lkp_index = '0; lkp_tag = '0;
        upd_valid = 1'b0; upd_op = 1'b0; upd_index = '0; upd_tag = '0;
        upd_taken = 1'b0; upd_u_inc = 1'b0; upd_u_dec = 1'b0;
        repeat (3) @(negedge Clk);
        chk_en = 1;
        chk("reset_init_done", int'(init_done), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);

        lkp_valid = 1'b1; lkp_index = 10'd5;
        reset = 1'b1;
        wait_init("init_cycles");
        do_lkp(5, 0);
        chk("l0_valid", int'(rsp_valid), 1);
        chk("l0_hit", int'(rsp_hit), 0);
        chk("l0_ctr", int'(rsp_ctr), 0);

        do_upd(1, 5, 'h3C, 1, 0, 0, f);
        chk("alloc_ok_fail", f, 0);
        do_lkp(5, 'h3C);
        chk("a_hit", int'(rsp_hit), 1);
        chk("a_ctr", int'(rsp_ctr), 4);
        chk("a_pred", int'(rsp_pred), 1);
        chk("a_weak", int'(rsp_weak), 1);
        chk("a_u", int'(rsp_u), 0);
        do_lkp(5, 'h3D);
        chk("a_tagmiss", int'(rsp_hit), 0);

        for (int i = 0; i < 5; i++) do_upd(0, 5, 0, 1, 0, 0, f);
        do_lkp(5, 'h3C);
        chk("sat_hi_ctr", int'(rsp_ctr), 7);
        chk("sat_hi_weak", int'(rsp_weak), 0);
        for (int i = 0; i < 4; i++) do_upd(0, 5, 0, 0, 0, 0, f);
        do_lkp(5, 'h3C);
        chk("ctr3", int'(rsp_ctr), 3);
        chk("ctr3_weak", int'(rsp_weak), 1);
        chk("ctr3_pred", int'(rsp_pred), 0);
        for (int i = 0; i < 5; i++) do_upd(0, 5, 0, 0, 0, 0, f);
        do_lkp(5, 'h3C);
        chk("sat_lo_ctr", int'(rsp_ctr), 0);
        chk("sat_lo_weak", int'(rsp_weak), 0);

        // 16th update: starts a sweep so the u sequence below starts fresh
        do_upd(0, 100, 0, 0, 0, 0, f);
        do_upd(0, 5, 0, 0, 1, 0, f);
        do_upd(0, 5, 0, 0, 1, 1, f);
        do_upd(1, 5, 'h11, 1, 0, 0, f);
        chk("fail1", f, 1);
        do_lkp(5, 'h3C);
        chk("fail1_hit", int'(rsp_hit), 1);
        chk("fail1_u", int'(rsp_u), 1);
        do_upd(1, 5, 'h11, 1, 0, 0, f);
        chk("fail2", f, 1);
        do_upd(1, 5, 'h11, 1, 0, 0, f);
        chk("fail3", f, 0);
        do_lkp(5, 'h11);
        chk("realloc_hit", int'(rsp_hit), 1);
        chk("realloc_ctr", int'(rsp_ctr), 4);
        chk("realloc_u", int'(rsp_u), 0);

        for (int i = 0; i < 3; i++) do_upd(0, 200, 0, 0, 0, 0, f);
        do_upd(1, 0, 'h22, 1, 0, 0, f);
        do_upd(0, 0, 0, 1, 1, 0, f);
        do_upd(0, 0, 0, 1, 1, 0, f);
        do_upd(0, 0, 0, 1, 1, 0, f);
        chk("age_ready_drop", int'(upd_ready), 0);
        lkp_valid = 1'b1; lkp_index = 10'd0; lkp_tag = 8'h22;
        n = 0;
        do begin
            @(posedge Clk);
            n++;
            #1;
            if (n == 1) chk("age_preshift_u", int'(rsp_u), 3);
            if (n == 2) chk("age_postshift_u", int'(rsp_u), 1);
        end while (!upd_ready && n < 2000);
        chk("age_cycles", n, D);
        @(negedge Clk);
        lkp_valid = 1'b0;
        do_lkp(0, 'h22);
        chk("aged_u", int'(rsp_u), 1);

        for (int i = 0; i < 4; i++) do_upd(0, 300, 0, 0, 0, 0, f);
        repeat (300) @(negedge Clk);
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        wait_init("reinit_cycles");
        do_lkp(0, 'h22);
        chk("clr0_hit", int'(rsp_hit), 0);
        chk("clr0_u", int'(rsp_u), 0);
        do_lkp(5, 'h11);
        chk("clr5_hit", int'(rsp_hit), 0);
        chk("clr5_ctr", int'(rsp_ctr), 0);

        do_upd(1, 9, 'h5A, 1, 0, 0, f);
        lkp_valid = 1'b1; lkp_index = 10'd9; lkp_tag = 8'h5A;
        upd_valid = 1'b1; upd_op = 1'b0; upd_index = 10'd9;
        upd_taken = 1'b1; upd_u_inc = 1'b0; upd_u_dec = 1'b0;
        @(negedge Clk);
        lkp_valid = 1'b0; upd_valid = 1'b0;
        chk("coll_pre_ctr", int'(rsp_ctr), 4);
        do_lkp(9, 'h5A);
        chk("coll_post_ctr", int'(rsp_ctr), 5);

        acc = 0;
        cyc = 0;
        while (acc < 120 && cyc < 60000) begin
            lkp_valid = 1'($urandom_range(0, 1));
            lkp_index = ($urandom_range(0, 3) == 0) ?
                        IL'(D - 8 + $urandom_range(0, 7)) : IL'($urandom_range(0, 7));
            lkp_tag   = TL'($urandom_range(0, 3));
            upd_valid = 1'($urandom_range(0, 1));
            upd_op    = 1'($urandom_range(0, 1));
            upd_index = ($urandom_range(0, 3) == 0) ?
                        IL'(D - 8 + $urandom_range(0, 7)) : IL'($urandom_range(0, 7));
            upd_tag   = TL'($urandom_range(0, 3));
            upd_taken = 1'($urandom_range(0, 1));
            upd_u_inc = 1'($urandom_range(0, 1));
            upd_u_dec = 1'($urandom_range(0, 1));
            if (upd_valid && upd_ready) acc++;
            @(negedge Clk);
            cyc++;
        end
        chk("rand_progress", (acc >= 120) ? 1 : 0, 1);
        lkp_valid = 1'b0; upd_valid = 1'b0;
        repeat (4) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tage_bank.md
Name: tage_bank

Overview:
- Next-generation parametrised TAGE tagged component; one instance per history length in the TAGE predictor.
- Performs the tag compare internally and returns hit, prediction, weak and useful status one cycle after a lookup.
- Applies train and allocate updates through a valid/ready port.
- Clears itself after reset with a hardware sweep FSM, so it needs no initial block.
- Ages useful bits periodically: a sweep halves every u field.

Parameters:
- IL, 10: index width; depth = 2^IL entries.
- TAG_LEN, 8: tag width.
- UL, 2: useful-counter width.
- CL, 3: prediction-counter width; MSB gives the predicted direction.
- AGE_PERIOD, 256: accepted updates between aging sweeps; must be >= 1.

Ports:
- Clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- init_done  out  1  high once the clear sweep is complete.
- lkp_valid  in  1  lookup request.
- lkp_ready  out  1  lookup accepted when valid & ready.
- lkp_index  in  IL  lookup index.
- lkp_tag  in  TAG_LEN  lookup tag.
- rsp_valid  out  1  response valid; one-cycle pulse.
- rsp_hit  out  1  entry valid and stored tag equals lkp_tag.
- rsp_pred  out  1  counter MSB; 0 when no hit.
- rsp_weak  out  1  counter is 2^(CL-1) or 2^(CL-1)-1; 0 when no hit.
- rsp_u  out  UL  useful bits; 0 when no hit.
- rsp_ctr  out  CL  counter value; 0 when no hit.
- upd_valid  in  1  update request.
- upd_ready  out  1  update accepted when valid & ready.
- upd_op  in  1  0 = TRAIN, 1 = ALLOC.
- upd_index  in  IL  update index.
- upd_tag  in  TAG_LEN  tag written on ALLOC.
- upd_taken  in  1  resolved branch direction.
- upd_u_inc  in  1  TRAIN only: increment u.
- upd_u_dec  in  1  TRAIN only: decrement u.
- upd_alloc_fail  out  1  one-cycle pulse: ALLOC refused because u != 0.

Behaviour:
- Entry fields: valid(1), tag, ctr, u.
- FSM states: INIT, RUN, AGE.
- reset=0 at any clock edge:
  - state <= INIT, sweep pointer <= 0, age counter <= 0.
  - All outputs low: init_done, lkp_ready, upd_ready, rsp_* all 0, upd_alloc_fail=0.
  - Applies even mid-sweep or mid-AGE; the sweep restarts at 0.
- INIT:
  - Each cycle, entry[ptr] is cleared to all zero fields and ptr increments.
  - After ptr = 2^IL-1 is cleared, go to RUN and set init_done=1.
  - INIT lasts exactly 2^IL cycles after reset deasserts.
  - lkp_ready=0 and upd_ready=0 throughout.
- RUN: lkp_ready=1, upd_ready=1.
- AGE:
  - Each cycle, entry[ptr].u <= u >> 1 (logical shift) and ptr increments.
  - After the last entry, return to RUN and clear the age counter.
  - lkp_ready=1, upd_ready=0.
- Lookup:
  - Accepted at edge N; rsp_valid=1 with response fields at edge N+1.
  - Response fields hold until the next accepted lookup; rsp_valid is otherwise 0.
  - Fully pipelined: one lookup per cycle.
- TRAIN, on an accepted update:
  - If upd_taken, ctr increments, saturating at all-ones; otherwise ctr decrements, saturating at 0.
  - ctr is unchanged if the entry is invalid.
  - upd_u_inc increments u, saturating at all-ones; upd_u_dec decrements u, saturating at 0.
  - If upd_u_inc and upd_u_dec are both set, inc wins.
  - Tag is never changed.
- ALLOC, on an accepted update:
  - If u==0: valid=1, tag<=upd_tag, u=0, ctr = 2^(CL-1) if taken, else 2^(CL-1)-1.
  - If u!=0: u decrements, the entry is otherwise unchanged, and upd_alloc_fail pulses at the next edge.
- Aging trigger:
  - The age counter increments on every accepted update.
  - The accepted update that brings the count to AGE_PERIOD moves the FSM to AGE at the same edge; that update is still applied.
- Collisions:
  - A lookup and an update to the same index in the same cycle: the lookup returns pre-update data.
  - A lookup and the AGE sweep hitting the same index in the same cycle: the lookup returns the pre-shift u.
  - The next cycle sees the new data.
- Widths: all arithmetic is within the field width; no wrap-around is permitted, because every counter saturates.

Test Plan:
- Reset, then hold lkp_valid: ready stays 0 for 1024 cycles, then init_done=1; a lookup of idx 5 gives rsp_hit=0, rsp_ctr=0.
- ALLOC idx 5, tag 0x3C, taken=1, then lookup idx 5 tag 0x3C: hit=1, ctr=4, pred=1, weak=1, u=0; lookup with tag 0x3D gives hit=0.
- TRAIN taken x5 on idx 5: ctr saturates at 7. TRAIN not-taken x9: ctr saturates at 0. weak=1 only at ctr 3 or 4.
- Raise u on idx 5 to 2, then ALLOC with tag 0x11: upd_alloc_fail pulses, u=1, tag stays 0x3C; a second ALLOC makes u=0; a third ALLOC writes tag 0x11.
- AGE_PERIOD=4, u=3 on idx 0:
  - The 4th accepted update drops upd_ready for 1024 cycles while lookups continue.
  - Afterwards u(idx 0)=1.
  - Pull reset low mid-sweep: init restarts and all entries read 0 afterwards.
- Same-cycle lookup and TRAIN on idx 9 (ctr 4, taken): the response shows ctr=4; the next lookup shows ctr=5.
